// File: rtl/frame_cmd_writer.sv
// Byte-stream command decoder for the LED matrix: channel/brightness enables, line/frame writes, frame clear.
// Writes land on the RAM port one edge after byte acceptance; rx_ready drops only while clearing.
module frame_cmd_writer #(
    parameter int ROW_BITS        = 5,
    parameter int COL_BITS        = 6,
    parameter int BPP_BITS        = 1,
    parameter int CHANNELS        = 3,
    parameter int BRIGHTNESS_BITS = 6,
    parameter bit COL_MIRROR      = 1'b1,
    localparam int ADDR_WIDTH     = ROW_BITS + COL_BITS + BPP_BITS
) (
    input  logic                       ram_clk_enable,
    input  logic                       reset,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    input  logic                       rx_invalid,
    output logic                       rx_ready,
    output logic [CHANNELS-1:0]        channel_enable,
    output logic [BRIGHTNESS_BITS-1:0] brightness_enable,
    output logic [ADDR_WIDTH-1:0]      ram_address,
    output logic [7:0]                 ram_data_out,
    output logic                       ram_write_enable,
    output logic                       busy,
    output logic                       cmd_error
);

    // byte_idx keeps one bit even for one-byte pixels; it then simply stays 0
    localparam int BI_W = (BPP_BITS > 0) ? BPP_BITS : 1;
    localparam logic [BI_W-1:0] BYTE_LAST = BI_W'((1 << BPP_BITS) - 1);

    typedef enum logic [2:0] {S_IDLE, S_MASK, S_ROW, S_DATA, S_CLEAR} state_t;

    state_t                     state, state_nxt;
    logic [ROW_BITS-1:0]        row, row_nxt;
    logic [COL_BITS-1:0]        col, col_nxt, col_mapped;
    logic [BI_W-1:0]            byte_idx, byte_idx_nxt;
    logic                       frame_mode, frame_mode_nxt;
    logic [ADDR_WIDTH-1:0]      clr_addr, clr_addr_nxt;
    logic [CHANNELS-1:0]        channel_enable_nxt;
    logic [BRIGHTNESS_BITS-1:0] brightness_enable_nxt;
    logic [ADDR_WIDTH-1:0]      ram_address_nxt, data_addr;
    logic [7:0]                 ram_data_out_nxt;
    logic                       ram_write_enable_nxt, cmd_error_nxt, xfer;

    function automatic logic [7:0] chan_letter(input int c);
        case (c)
            0:       chan_letter = 8'h52; // 'R'
            1:       chan_letter = 8'h47; // 'G'
            default: chan_letter = 8'h42; // 'B'
        endcase
    endfunction

    assign rx_ready   = (state != S_CLEAR);
    assign busy       = (state != S_IDLE);
    assign xfer       = rx_valid & rx_ready;
    assign col_mapped = COL_MIRROR ? ~col : col;
    assign data_addr  = (ADDR_WIDTH'({row, col_mapped}) << BPP_BITS) | ADDR_WIDTH'(byte_idx);

    always_comb begin
        state_nxt             = state;
        row_nxt               = row;
        col_nxt               = col;
        byte_idx_nxt          = byte_idx;
        frame_mode_nxt        = frame_mode;
        clr_addr_nxt          = clr_addr;
        channel_enable_nxt    = channel_enable;
        brightness_enable_nxt = brightness_enable;
        ram_address_nxt       = ram_address;
        ram_data_out_nxt      = ram_data_out;
        ram_write_enable_nxt  = 1'b0;
        cmd_error_nxt         = 1'b0;

        case (state)
            S_IDLE: begin
                if (xfer && !rx_invalid) begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        if (c < 3) begin
                            if (rx_data == chan_letter(c))
                                channel_enable_nxt[c] = 1'b1;
                            else if (rx_data == (chan_letter(c) | 8'h20))
                                channel_enable_nxt[c] = 1'b0;
                        end
                    end
                    // digit k toggles plane BRIGHTNESS_BITS-k, so walk bits and derive their digit
                    for (int b = 0; b < BRIGHTNESS_BITS; b++) begin
                        if (rx_data == 8'h30 + 8'(BRIGHTNESS_BITS - b))
                            brightness_enable_nxt[b] = ~brightness_enable[b];
                    end
                    case (rx_data)
                        8'h30: brightness_enable_nxt = '0;
                        8'h39: brightness_enable_nxt = '1;
                        8'h4D: state_nxt = S_MASK;
                        8'h4C: state_nxt = S_ROW;
                        8'h46: begin
                            row_nxt        = '0;
                            col_nxt        = '0;
                            byte_idx_nxt   = BYTE_LAST;
                            frame_mode_nxt = 1'b1;
                            state_nxt      = S_DATA;
                        end
                        8'h43: begin
                            clr_addr_nxt = '0;
                            state_nxt    = S_CLEAR;
                        end
                        default: ;
                    endcase
                end
            end

            S_MASK: begin
                if (xfer) begin
                    if (rx_invalid)
                        cmd_error_nxt = 1'b1;
                    else
                        channel_enable_nxt = rx_data[CHANNELS-1:0];
                    state_nxt = S_IDLE;
                end
            end

            S_ROW: begin
                if (xfer) begin
                    if (rx_invalid) begin
                        cmd_error_nxt = 1'b1;
                        state_nxt     = S_IDLE;
                    end else begin
                        row_nxt        = rx_data[ROW_BITS-1:0];
                        col_nxt        = '0;
                        byte_idx_nxt   = BYTE_LAST;
                        frame_mode_nxt = 1'b0;
                        state_nxt      = S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (xfer) begin
                    if (rx_invalid) begin
                        cmd_error_nxt = 1'b1;
                        state_nxt     = S_IDLE;
                    end else begin
                        ram_address_nxt      = data_addr;
                        ram_data_out_nxt     = rx_data;
                        ram_write_enable_nxt = 1'b1;
                        if (byte_idx == '0) begin
                            byte_idx_nxt = BYTE_LAST;
                            col_nxt      = col + 1'b1;
                            if (&col) begin
                                if (!frame_mode || &row)
                                    state_nxt = S_IDLE;
                                else
                                    row_nxt = row + 1'b1;
                            end
                        end else begin
                            byte_idx_nxt = byte_idx - 1'b1;
                        end
                    end
                end
            end

            S_CLEAR: begin
                ram_address_nxt      = clr_addr;
                ram_data_out_nxt     = 8'h00;
                ram_write_enable_nxt = 1'b1;
                clr_addr_nxt         = clr_addr + 1'b1;
                if (&clr_addr)
                    state_nxt = S_IDLE;
            end

            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ram_clk_enable or posedge reset) begin
        if (reset) begin
            state             <= S_IDLE;
            row               <= '0;
            col               <= '0;
            byte_idx          <= '0;
            frame_mode        <= 1'b0;
            clr_addr          <= '0;
            channel_enable    <= '1;
            brightness_enable <= '1;
            ram_address       <= '0;
            ram_data_out      <= '0;
            ram_write_enable  <= 1'b0;
            cmd_error         <= 1'b0;
        end else begin
            state             <= state_nxt;
            row               <= row_nxt;
            col               <= col_nxt;
            byte_idx          <= byte_idx_nxt;
            frame_mode        <= frame_mode_nxt;
            clr_addr          <= clr_addr_nxt;
            channel_enable    <= channel_enable_nxt;
            brightness_enable <= brightness_enable_nxt;
            ram_address       <= ram_address_nxt;
            ram_data_out      <= ram_data_out_nxt;
            ram_write_enable  <= ram_write_enable_nxt;
            cmd_error         <= cmd_error_nxt;
        end
    end

endmodule
